// File: rtl/mem_stage_lsu_pkg.sv
// Purpose : shared types and helpers for the memory-stage load/store unit.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_lsu_pkg;

    // Memory-access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Bytes per data-memory word.
    localparam int kByteLanes = 4;

    // Access controls latched together with the operation.
    typedef struct packed {
        logic is_store;
        logic is_byte;
    } lsu_ctl_t;

    // One-hot write strobe for a single byte lane (little-endian).
    function automatic logic [kByteLanes-1:0] lane_mask(input logic [1:0] lane);
        return kByteLanes'(1) << lane;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Purpose : byte-lane steering -- SB replication/strobe and LBU lane select with zero-extend.
// Latency : purely combinational.
// Backpressure: none; follows its inputs.
// Ports   : lane/is_byte/is_store (access shape), store_data (rt value), rdata (memory word)
//           -> wdata, byte_en (write side), load_data (write-back value).
module lsu_byte_lane
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]            lane,
    input  logic                  is_byte,
    input  logic                  is_store,
    input  logic [31:0]           store_data,
    input  logic [31:0]           rdata,
    output logic [31:0]           wdata,
    output logic [kByteLanes-1:0] byte_en,
    output logic [31:0]           load_data
);

    always_comb begin
        // A byte store puts the byte on every lane; the strobe picks the target.
        wdata = is_byte ? {kByteLanes{store_data[7:0]}} : store_data;

        if (!is_store) begin
            byte_en = '0;
        end else if (is_byte) begin
            byte_en = lane_mask(lane);
        end else begin
            byte_en = '1;
        end

        load_data = is_byte ? {24'b0, rdata[8*lane +: 8]} : rdata;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Purpose : MEM-stage LSU; turns one EX/MEM memory op into a dmem request and returns load data.
// Latency : store IDLE,REQ,DONE (3 cycles, zero-wait); load IDLE,REQ,WAIT..,DONE.
// Backpressure: stall_o holds IF..MEM while a request waits for ready or a load waits for data.
// Ports   : clk, n_reset (sync, active low); op_valid_i/is_mem_op_i/is_store_op_i/is_byte_op_i,
//           addr_i, store_data_i, rd_i, flush_i from the pipeline; dmem_req_* / dmem_resp_* to
//           data memory; load_valid_o/load_data_o/load_rd_o write-back; stall_o; misalign_o.
// Option  : LSU_MISALIGN_TRAP_EN -- trap unaligned word accesses instead of forcing alignment.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  op_valid_i,
    input  logic                  is_mem_op_i,
    input  logic                  is_store_op_i,
    input  logic                  is_byte_op_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [RD_W-1:0]       rd_i,
    input  logic                  flush_i,
    output logic                  dmem_req_valid_o,
    input  logic                  dmem_req_ready_i,
    output logic [ADDR_W-1:0]     dmem_addr_o,
    output logic                  dmem_wen_o,
    output logic [kByteLanes-1:0] dmem_byte_en_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_resp_valid_i,
    input  logic [31:0]           dmem_rdata_i,
    output logic                  load_valid_o,
    output logic [31:0]           load_data_o,
    output logic [RD_W-1:0]       load_rd_o,
    output logic                  stall_o,
    output logic                  misalign_o
);

    lsu_state_e          state;
    logic [ADDR_W-1:0]   op_addr;
    logic [31:0]         op_data;
    logic [RD_W-1:0]     op_rd;
    lsu_ctl_t            op_ctl;
    logic                drop;
    logic [31:0]         ld_data_q;
    logic [RD_W-1:0]     ld_rd_q;

    logic                start_ok;
    logic                misalign;
    logic                accept_op;
    logic                req_active;
    logic [31:0]         lane_wdata;
    logic [kByteLanes-1:0] lane_be;
    logic [31:0]         lane_load;

    assign start_ok = op_valid_i & is_mem_op_i & ~flush_i;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = start_ok & ~is_byte_op_i & (addr_i[1:0] != 2'b00);
`else
    // Word ops simply drop addr[1:0]; nothing traps.
    assign misalign = 1'b0;
`endif

    assign accept_op  = (state == IDLE) & start_ok & ~misalign;
    assign req_active = (state == REQ);

    lsu_byte_lane u_lane (
        .lane       (op_addr[1:0]),
        .is_byte    (op_ctl.is_byte),
        .is_store   (op_ctl.is_store),
        .store_data (op_data),
        .rdata      (dmem_rdata_i),
        .wdata      (lane_wdata),
        .byte_en    (lane_be),
        .load_data  (lane_load)
    );

    // Request fields come only from latched state, so they stay put while ready is low.
    assign dmem_req_valid_o = req_active;
    assign dmem_addr_o      = req_active ? {op_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wen_o       = req_active & op_ctl.is_store;
    assign dmem_byte_en_o   = req_active ? lane_be : '0;
    assign dmem_wdata_o     = (req_active & op_ctl.is_store) ? lane_wdata : '0;

    assign load_valid_o = (state == DONE) & ~op_ctl.is_store & ~drop & ~flush_i;
    assign load_data_o  = ld_data_q;
    assign load_rd_o    = ld_rd_q;
    assign misalign_o   = (state == IDLE) & misalign;

    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = accept_op;   // hold the op in EX/MEM from its first cycle
            REQ:     stall_o = 1'b1;
            WAIT:    stall_o = 1'b1;
            DONE:    stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= IDLE;
            op_addr   <= '0;
            op_data   <= '0;
            op_rd     <= '0;
            op_ctl    <= '0;
            drop      <= 1'b0;
            ld_data_q <= '0;
            ld_rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A response showing up here belongs to nothing and is ignored.
                    if (accept_op) begin
                        op_addr         <= addr_i;
                        op_data         <= store_data_i;
                        op_rd           <= rd_i;
                        op_ctl.is_store <= is_store_op_i;
                        op_ctl.is_byte  <= is_byte_op_i;
                        drop            <= 1'b0;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    // Once memory has seen valid&ready the access is committed; a flush
                    // arriving in that same cycle only suppresses a load's write-back.
                    if (dmem_req_ready_i) begin
                        state <= op_ctl.is_store ? DONE : WAIT;
                        drop  <= flush_i & ~op_ctl.is_store;
                    end else if (flush_i) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    // The outstanding response must still be consumed after a flush.
                    drop <= drop | flush_i;
                    if (dmem_resp_valid_i) begin
                        ld_data_q <= lane_load;
                        ld_rd_q   <= op_rd;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    drop  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        op_valid_i, is_mem_op_i, is_store_op_i, is_byte_op_i, flush_i;
    logic [31:0] addr_i, store_data_i;
    logic [4:0]  rd_i;
    logic        dmem_req_valid_o, dmem_req_ready_i, dmem_wen_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, load_data_o;
    logic [3:0]  dmem_byte_en_o;
    logic        dmem_resp_valid_i, load_valid_o, stall_o, misalign_o;
    logic [4:0]  load_rd_o;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .RD_W(5)) dut (
        .clk(clk), .n_reset(n_reset),
        .op_valid_i(op_valid_i), .is_mem_op_i(is_mem_op_i), .is_store_op_i(is_store_op_i),
        .is_byte_op_i(is_byte_op_i), .addr_i(addr_i), .store_data_i(store_data_i), .rd_i(rd_i),
        .flush_i(flush_i),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_addr_o(dmem_addr_o), .dmem_wen_o(dmem_wen_o), .dmem_byte_en_o(dmem_byte_en_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_resp_valid_i(dmem_resp_valid_i),
        .dmem_rdata_i(dmem_rdata_i),
        .load_valid_o(load_valid_o), .load_data_o(load_data_o), .load_rd_o(load_rd_o),
        .stall_o(stall_o), .misalign_o(misalign_o)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct { logic [31:0] addr; logic wen; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] data; logic [4:0] rd; } ld_t;
    req_t exp_req[$];
    ld_t  exp_ld[$];

    // ---------------- reference memory (byte addressed) ----------------
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [7:0] t;
        t = a[7:0];
        return (t * 8'd37) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // ---------------- bus-side memory model ----------------
    logic [31:0] bus_mem [logic [31:0]];
    int   fix_rdy  = -1;   // -1: random ready wait
    int   fix_resp = -1;   // -1: random response delay
    bit   load_accepted = 1'b0;

    function automatic logic [31:0] bus_word(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return {init_byte(wa + 32'd3), init_byte(wa + 32'd2), init_byte(wa + 32'd1), init_byte(wa)};
    endfunction

    initial begin : responder
        int          resp_cnt;
        int          rdy_wait;
        bit          rdy_armed;
        logic [31:0] resp_word;
        logic [31:0] w;
        resp_cnt = 0; rdy_wait = 0; rdy_armed = 0; resp_word = '0;
        dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0; dmem_rdata_i = '0;
        forever begin
            @(negedge clk);
            dmem_resp_valid_i = 1'b0;
            dmem_rdata_i      = $urandom;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    dmem_resp_valid_i = 1'b1;
                    dmem_rdata_i      = resp_word;
                end
            end
            dmem_req_ready_i = 1'b0;
            if (dmem_req_valid_o && n_reset) begin
                if (!rdy_armed) begin
                    rdy_armed = 1'b1;
                    rdy_wait  = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
                end
                if (rdy_wait == 0) begin
                    dmem_req_ready_i = 1'b1;
                    rdy_armed = 1'b0;
                    if (dmem_wen_o) begin
                        w = bus_word(dmem_addr_o);
                        for (int i = 0; i < 4; i++)
                            if (dmem_byte_en_o[i]) w[8*i +: 8] = dmem_wdata_o[8*i +: 8];
                        bus_mem[dmem_addr_o] = w;
                    end else begin
                        resp_word     = bus_word(dmem_addr_o);
                        resp_cnt      = (fix_resp >= 0) ? fix_resp : int'($urandom_range(1, 4));
                        load_accepted = 1'b1;
                    end
                end else begin
                    rdy_wait--;
                end
            end
        end
    end

    // ---------------- monitor: 1 time unit before each rising edge ----------------
    initial begin : monitor
        bit   pend;
        req_t held;
        req_t e;
        ld_t  l;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (pend) begin
                chk("req_hold_valid", dmem_req_valid_o, 1'b1);
                chk("req_hold_addr", dmem_addr_o, held.addr);
                chk("req_hold_be", dmem_byte_en_o, held.be);
            end
            pend = 1'b0;
            if (dmem_req_valid_o && dmem_req_ready_i) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_request", 1'b1, 1'b0);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_addr", dmem_addr_o, e.addr);
                    chk("req_wen", dmem_wen_o, e.wen);
                    chk("req_byte_en", dmem_byte_en_o, e.be);
                    if (e.wen) chk("req_wdata", dmem_wdata_o, e.wdata);
                end
            end else if (dmem_req_valid_o) begin
                pend = 1'b1;
                held.addr = dmem_addr_o; held.be = dmem_byte_en_o;
            end
            if (load_valid_o) begin
                if (exp_ld.size() == 0) begin
                    chk("spurious_load_valid", 1'b1, 1'b0);
                end else begin
                    l = exp_ld.pop_front();
                    chk("load_data", load_data_o, l.data);
                    chk("load_rd", load_rd_o, l.rd);
                end
            end
        end
    end

    // ---------------- driver + reference model ----------------
    // Called at a falling edge; presents one EX/MEM op until the pipeline advances.
    task automatic run_op(input logic mem, input logic st, input logic byt,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic flsh, output int stalls);
        bit          trap, saw, flushed, done, s;
        logic [31:0] wa, ld;
        req_t        r;
        ld_t         l;
        trap = TRAP && mem && !byt && (addr[1:0] != 2'b00);
        op_valid_i = 1'b1; is_mem_op_i = mem; is_store_op_i = st; is_byte_op_i = byt;
        addr_i = addr; store_data_i = data; rd_i = rd; flush_i = 1'b0;
        load_accepted = 1'b0;
        if (mem && !trap) begin
            wa = {addr[31:2], 2'b00};
            r.addr = wa; r.wen = st; r.wdata = '0; r.be = 4'h0;
            if (st && byt) begin
                r.be = 4'b0001 << addr[1:0];
                r.wdata = {4{data[7:0]}};
                ref_mem[addr] = data[7:0];
            end else if (st) begin
                r.be = 4'hF;
                r.wdata = data;
                for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = data[8*i +: 8];
            end
            exp_req.push_back(r);
            if (!st) begin
                if (byt) ld = {24'b0, ref_byte(addr)};
                else     ld = {ref_byte(wa + 32'd3), ref_byte(wa + 32'd2),
                               ref_byte(wa + 32'd1), ref_byte(wa)};
                l.data = ld; l.rd = rd;
                if (!flsh) exp_ld.push_back(l);
            end
        end
        saw = 0; flushed = 0; done = 0; stalls = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            flush_i = 1'b0;
            if (flsh && saw && !flushed) begin
                flush_i = 1'b1;
                flushed = 1'b1;
            end
            #1;
            if (load_accepted) saw = 1'b1;
            s = stall_o;
            if (c == 0) begin
                chk("misalign_first", misalign_o, trap);
                chk("stall_first", s, mem && !trap);
            end
            if (s) stalls++;
            @(posedge clk);
            if (!s) done = 1'b1;
            @(negedge clk);
        end
        if (!done) chk("op_timeout", 1'b0, 1'b1);
        op_valid_i = 1'b0; is_mem_op_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_valid"}, dmem_req_valid_o, 0);
        chk({tag, "_addr"}, dmem_addr_o, 0);
        chk({tag, "_wen"}, dmem_wen_o, 0);
        chk({tag, "_byte_en"}, dmem_byte_en_o, 0);
        chk({tag, "_wdata"}, dmem_wdata_o, 0);
        chk({tag, "_load_valid"}, load_valid_o, 0);
        chk({tag, "_load_data"}, load_data_o, 0);
        chk({tag, "_load_rd"}, load_rd_o, 0);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_misalign"}, misalign_o, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  st_cnt;
        bit  got;
        ld_t l;
        n_reset = 1'b0; op_valid_i = 0; is_mem_op_i = 0; is_store_op_i = 0; is_byte_op_i = 0;
        addr_i = '0; store_data_i = '0; rd_i = '0; flush_i = 0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);

        // SW, immediate ready: stalled in IDLE and REQ only.
        fix_rdy = 0; fix_resp = 1;
        run_op(1, 1, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, st_cnt);
        chk("sw_stall_cycles", st_cnt, 2);

        // SB to lane 3.
        run_op(1, 1, 1, 32'h13, 32'h000000A5, 5'd0, 0, st_cnt);
        chk("sb_stall_cycles", st_cnt, 2);

        // LBU lane 1 of 0x11223344, response 3 cycles after accept.
        run_op(1, 1, 0, 32'h20, 32'h11223344, 5'd0, 0, st_cnt);
        fix_resp = 3;
        run_op(1, 0, 1, 32'h21, 32'h0, 5'd9, 0, st_cnt);
        chk("lbu_stall_cycles", st_cnt, 5);
        chk("lbu_value", load_data_o, 32'h00000033);
        run_op(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, st_cnt);
        chk("nonmem_stall_cycles", st_cnt, 0);
        run_op(1, 1, 0, 32'h24, 32'hCAFEF00D, 5'd0, 0, st_cnt);
        chk("load_data_hold", load_data_o, 32'h00000033);
        chk("load_rd_hold", load_rd_o, 5'd9);

        // LW with ready held low for 5 cycles.
        fix_rdy = 5; fix_resp = 1;
        run_op(1, 0, 0, 32'h10, 32'h0, 5'd3, 0, st_cnt);
        chk("lw_slow_stall_cycles", st_cnt, 8);

        // LW flushed while waiting: response consumed, no write-back; then a clean LW.
        fix_rdy = 0; fix_resp = 3;
        run_op(1, 0, 0, 32'h10, 32'h0, 5'd4, 1, st_cnt);
        chk("flush_stall_cycles", st_cnt, 5);
        run_op(0, 1, 1, 32'h13, 32'h0, 5'd0, 0, st_cnt);
        chk("after_flush_idle", st_cnt, 0);
        fix_resp = 1;
        run_op(1, 0, 0, 32'h20, 32'h0, 5'd5, 0, st_cnt);

        // Reset while a load waits; its late response must be ignored.
        fix_rdy = 0; fix_resp = 4;
        op_valid_i = 1; is_mem_op_i = 1; is_store_op_i = 0; is_byte_op_i = 0;
        addr_i = 32'h44; rd_i = 5'd7; flush_i = 0;
        load_accepted = 1'b0;
        exp_req.push_back('{addr: 32'h44, wen: 1'b0, be: 4'h0, wdata: 32'h0});
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (load_accepted) got = 1'b1;
        end
        chk("reset_test_accept", got, 1'b1);
        @(negedge clk);
        n_reset = 1'b0; op_valid_i = 0; is_mem_op_i = 0;
        @(posedge clk);
        #1;
        check_all_zero("reset_wait");
        @(negedge clk);
        n_reset = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("late_resp_stall", stall_o, 0);
        @(negedge clk);

        // Word load at a misaligned address.
        fix_resp = 1;
        run_op(1, 0, 0, 32'h2, 32'h0, 5'd6, 0, st_cnt);
        chk("misalign_lw_stall_cycles", st_cnt, TRAP ? 0 : 3);

        // Randomized mix.
        fix_rdy = -1; fix_resp = -1;
        for (int n = 0; n < 150; n++) begin
            logic        mem, st, byt, fl;
            logic [31:0] a;
            mem = ($urandom_range(0, 4) != 0);
            st  = $urandom_range(0, 1);
            byt = $urandom_range(0, 1);
            a   = 32'h40 + 32'($urandom_range(0, 31));
            fl  = mem && !st && ($urandom_range(0, 5) == 0);
            run_op(mem, st, byt, a, $urandom, 5'($urandom_range(0, 31)), fl, st_cnt);
        end

        repeat (10) @(negedge clk);
        chk("exp_req_drained", exp_req.size(), 0);
        chk("exp_load_drained", exp_ld.size(), 0);
        while (exp_ld.size() > 0) l = exp_ld.pop_front();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
